// File: rtl/ut_control_unit.sv
`default_nettype none
// ============================================================================
// ut_control_unit -- multi-cycle fetch/decode/execute sequencer for the UT
//                    accumulator processor.
// Revision: 1.0
// ============================================================================
module ut_control_unit #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [ADDR_WIDTH+1:0] mem_data_in,
  input  logic                  carry_in,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic                  load_acc,
  output logic                  alu_sel,
  output logic                  load_carry,
  output logic                  clear_carry,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  localparam int IW = ADDR_WIDTH + 2;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_OPERAND = 3'd2,
    S_EXEC    = 3'd3,
    S_STORE   = 3'd4,
    S_JUMP    = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [IW-1:0]         ir, ir_nxt;

  logic [1:0]            opcode;
  logic [ADDR_WIDTH-1:0] target;

  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  en_d, we_d, acc_d, sel_d, lc_d, cc_d;
  logic                  active;

  assign opcode = ir[IW-1:IW-2];
  assign target = ir[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
    end else if (ce) begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

  always_comb begin
    state_nxt = S_FETCH;
    pc_nxt    = pc;
    ir_nxt    = ir;
    addr_d    = pc;
    en_d      = 1'b0;
    we_d      = 1'b0;
    acc_d     = 1'b0;
    sel_d     = 1'b0;
    lc_d      = 1'b0;
    cc_d      = 1'b0;
    case (state)
      S_FETCH: begin
        en_d      = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ir_nxt = mem_data_in;
        pc_nxt = pc + ADDR_WIDTH'(1);
        case (mem_data_in[IW-1:IW-2])
          2'b10:   state_nxt = S_STORE;
          2'b11:   state_nxt = S_JUMP;
          default: state_nxt = S_OPERAND;
        endcase
      end
      S_OPERAND: begin
        addr_d    = target;
        en_d      = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        addr_d = target;
        acc_d  = 1'b1;
        sel_d  = opcode[0];
        lc_d   = (opcode == 2'b01);
      end
      S_STORE: begin
        addr_d = target;
        en_d   = 1'b1;
        we_d   = 1'b1;
      end
      S_JUMP: begin
        addr_d = target;
        // A set carry means "condition failed": fall through and consume it.
        if (carry_in) cc_d   = 1'b1;
        else          pc_nxt = target;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Strobes are suppressed whenever the state cannot advance.
  assign active      = ce & ~rst;
  assign mem_en      = en_d  & active;
  assign mem_we      = we_d  & active;
  assign load_acc    = acc_d & active;
  assign load_carry  = lc_d  & active;
  assign clear_carry = cc_d  & active;
  assign mem_addr    = rst ? '0 : addr_d;
  assign alu_sel     = rst ? 1'b0 : sel_d;
  assign pc_out      = pc;

endmodule
`default_nettype wire

// File: tb/tb_ut_control_unit.sv
`default_nettype none
// ============================================================================
// tb_ut_control_unit -- directed self-checking bench for ut_control_unit.
// Revision: 1.0
// ============================================================================
module tb_ut_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b1;
  logic [7:0] mem_data_in = 8'h00;
  logic       carry_in = 1'b0;
  logic [5:0] mem_addr;
  logic       mem_en, mem_we, load_acc, alu_sel, load_carry, clear_carry;
  logic [5:0] pc_out;

  logic [7:0] ram [0:63];
  int         passed = 0;
  int         total = 0;

  ut_control_unit #(.ADDR_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .ce(ce), .mem_data_in(mem_data_in),
    .carry_in(carry_in), .mem_addr(mem_addr), .mem_en(mem_en),
    .mem_we(mem_we), .load_acc(load_acc), .alu_sel(alu_sel),
    .load_carry(load_carry), .clear_carry(clear_carry), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model.
  always @(posedge clk)
    if (mem_en && !mem_we) mem_data_in <= ram[mem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compares {mem_addr, mem_en, mem_we, load_acc, alu_sel, load_carry, clear_carry} and pc_out.
  task automatic chk(input string tag, input logic [5:0] addr, input logic [5:0] strb,
                     input logic [5:0] pc);
    logic [17:0] obs, exp;
    obs = {mem_addr, mem_en, mem_we, load_acc, alu_sel, load_carry, clear_carry, pc_out};
    exp = {addr, strb, pc};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed addr=%0h strb=%b pc=%0h, expected addr=%0h strb=%b pc=%0h",
                tag, obs[17:12], obs[11:6], obs[5:0], exp[17:12], exp[11:6], exp[5:0]);
  endtask

  // strb bit order: en we acc sel lc cc
  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 8'h00;
    ram[0]    = 8'h45;  // ADD 5
    ram[1]    = 8'h8A;  // STA 10
    ram[2]    = 8'hE0;  // JCC 0x20
    ram[6'h20] = 8'hE0; // JCC 0x20 (taken with carry set -> falls through)
    ram[6'h21] = 8'hFF; // JCC 63
    ram[63]   = 8'h03;  // NOR 3

    step(); step();
    chk("reset_hold", 6'h00, 6'b000000, 6'h00);
    rst = 1'b0;
    #1;
    chk("add_fetch", 6'h00, 6'b100000, 6'h00);
    step(); chk("add_decode", 6'h00, 6'b000000, 6'h00);
    step(); chk("add_operand", 6'h05, 6'b100000, 6'h01);
    step(); chk("add_exec", 6'h05, 6'b001110, 6'h01);
    step(); chk("sta_fetch", 6'h01, 6'b100000, 6'h01);

    step(); chk("sta_decode", 6'h01, 6'b000000, 6'h01);
    step(); chk("sta_store", 6'h0A, 6'b110000, 6'h02);
    step(); chk("jcc0_fetch", 6'h02, 6'b100000, 6'h02);

    carry_in = 1'b0;
    step(); chk("jcc0_decode", 6'h02, 6'b000000, 6'h02);
    step(); chk("jcc0_jump", 6'h20, 6'b000000, 6'h03);
    step(); chk("jcc0_target_fetch", 6'h20, 6'b100000, 6'h20);

    carry_in = 1'b1;
    step(); chk("jcc1_decode", 6'h20, 6'b000000, 6'h20);
    step(); chk("jcc1_jump", 6'h20, 6'b000001, 6'h21);
    step(); chk("jcc1_fallthrough", 6'h21, 6'b100000, 6'h21);

    carry_in = 1'b0;
    step(); step(); step();
    chk("jcc63_fetch", 6'h3F, 6'b100000, 6'h3F);
    step(); chk("nor_decode", 6'h3F, 6'b000000, 6'h3F);
    step(); chk("nor_operand_wrap", 6'h03, 6'b100000, 6'h00);
    step(); chk("nor_exec", 6'h03, 6'b001000, 6'h00);
    step(); chk("wrap_fetch", 6'h00, 6'b100000, 6'h00);

    step(); step();
    chk("ce_operand", 6'h05, 6'b100000, 6'h01);
    ce = 1'b0;
    #1;
    chk("ce_off0", 6'h05, 6'b000000, 6'h01);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("ce_off%0d", i), 6'h05, 6'b000000, 6'h01);
    end
    ce = 1'b1;
    #1;
    chk("ce_resume_operand", 6'h05, 6'b100000, 6'h01);
    step(); chk("ce_resume_exec", 6'h05, 6'b001110, 6'h01);
    step(); chk("ce_resume_fetch", 6'h01, 6'b100000, 6'h01);

    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    step(); step(); step();
    chk("rst2_exec", 6'h05, 6'b001110, 6'h01);
    rst = 1'b1;
    #1;
    chk("rst_in_exec", 6'h00, 6'b000000, 6'h01);
    step();
    rst = 1'b0;
    #1;
    chk("rst_abort_fetch", 6'h00, 6'b100000, 6'h00);
    step(); chk("rst_abort_decode", 6'h00, 6'b000000, 6'h00);
    step(); chk("rst_abort_operand", 6'h05, 6'b100000, 6'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/ut_control_unit.md
Name: ut_control_unit

Overview:
- Multi-cycle sequencer for the UT accumulator processor.
- Fetches and decodes instructions and drives the memory address, memory strobes, accumulator load and ALU select.
- Produces the carry-register control strobes (load_carry, clear_carry) and consumes the registered carry for the conditional jump.
- Sits directly upstream of the carry register and accumulator, and downstream of the synchronous program/data RAM.

Parameters:
- ADDR_WIDTH, 6, memory address width.
  - Instruction word width is ADDR_WIDTH+2: opcode in the top 2 bits, address in the low ADDR_WIDTH bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- ce  input  1  clock enable; when 0 the block holds all state
- mem_data_in  input  ADDR_WIDTH+2  RAM read data, valid the cycle after mem_en with mem_we=0
- carry_in  input  1  registered carry flag from the carry register
- mem_addr  output  ADDR_WIDTH  RAM address
- mem_en  output  1  RAM access strobe
- mem_we  output  1  RAM write strobe (the accumulator drives the write data)
- load_acc  output  1  accumulator captures the ALU result this cycle
- alu_sel  output  1  0 = NOR, 1 = ADD
- load_carry  output  1  carry register captures the ALU carry
- clear_carry  output  1  carry register clears
- pc_out  output  ADDR_WIDTH  current program counter (debug)

Behaviour:
- Registers: state, pc (ADDR_WIDTH), ir (ADDR_WIDTH+2). All update only when ce=1 and rst=0.
- Reset: synchronous.
  - rst=1 at an edge: state<=FETCH, pc<=0, ir<=0. Reset has priority over ce and aborts any in-flight instruction.
  - While rst=1, all strobes (mem_en, mem_we, load_acc, load_carry, clear_carry) are 0; alu_sel=0; mem_addr=0.
- Outputs are Moore, decoded from state and ir only. The exception is clear_carry in JUMP, which also depends on carry_in.
- ce=0: state, pc and ir hold, and every strobe is forced to 0. mem_addr and alu_sel keep their decoded value.
- Opcodes (ir top 2 bits): 00 NOR, 01 ADD, 10 STA, 11 JCC. Target address = ir low ADDR_WIDTH bits.
- States and outputs:
  - FETCH: mem_addr=pc, mem_en=1. Next DECODE.
  - DECODE: ir<=mem_data_in, pc<=pc+1 modulo 2^ADDR_WIDTH (max wraps to 0). mem_addr=pc. Next state is decoded from mem_data_in opcode: 00/01 -> OPERAND, 10 -> STORE, 11 -> JUMP.
  - OPERAND: mem_addr=target, mem_en=1. Next EXEC.
  - EXEC: mem_addr=target, load_acc=1, alu_sel=ir opcode bit 0, load_carry=1 only for ADD. Next FETCH.
  - STORE: mem_addr=target, mem_en=1, mem_we=1. Next FETCH.
  - JUMP: next FETCH.
    - carry_in=0: pc<=target, clear_carry=0.
    - carry_in=1: pc unchanged, clear_carry=1.
- Latency from FETCH entry to next FETCH entry (ce held 1): NOR/ADD 4 cycles, STA 3, JCC 3.
- load_carry and clear_carry are never asserted in the same cycle. mem_we is asserted only in STORE.
- The carry value is sampled in the JUMP cycle only. The carry register update caused by a preceding ADD is already visible then, because at least FETCH and DECODE intervene.
- Unused encodings of the state register return to FETCH.

Test Plan:
- Reset then release, RAM[0]=0x45 (ADD 5) -> FETCH addr 0, DECODE with ir=0x45, pc=1. OPERAND mem_addr=5 mem_en=1. EXEC load_acc=1 alu_sel=1 load_carry=1. Back to FETCH at cycle 4 with mem_addr=1.
- RAM[1]=0x8A (STA 10) -> exactly one cycle with mem_we=1, mem_en=1, mem_addr=10. No load_acc, load_carry or clear_carry. 3 cycles total.
- JCC 0x20 (0xE0) with carry_in=0 -> next FETCH mem_addr=0x20, clear_carry=0. The same instruction with carry_in=1 -> clear_carry=1 for one cycle, next FETCH mem_addr = old pc+1.
- pc=63, fetch NOR (0x03) -> pc_out=0 after DECODE. Following FETCH mem_addr=0.
- ce toggled 0 for 3 cycles during OPERAND -> state, pc and ir frozen, all strobes 0. Resumes into EXEC; the instruction completes in 4 enabled cycles.
- rst asserted one cycle during EXEC of ADD -> no load_acc/load_carry on that edge. Next cycle FETCH, mem_addr=0, pc_out=0, ir=0.
